// File: rtl/reg_file_flags.sv
// reg_file_flags: general-purpose register bank feeding the ALU operands,
// with write-through bypass, hardwired-zero r0, and latched zero/negative
// status flags for the branch logic.
module reg_file_flags #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  input  logic              cu_regWrite,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cu_flagWrite,
  input  logic              alu_zero,
  input  logic              alu_negative,
  output logic              flag_zero,
  output logic              flag_negative
);

  // One extra bit so NUM_REGS == 2**ADDR_W is representable for range checks.
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] rf_words [NUM_REGS];
  logic              wr_en;
  logic              flag_zero_reg;
  logic              flag_negative_reg;

  // A write is only real for a nonzero, in-range destination; everything
  // else (including bypass) keys off this single qualified enable.
  assign wr_en = cu_regWrite && (rd_addr != '0) && ({1'b0, rd_addr} < NUM_REGS_L);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_words[gi] = '0;
      end else begin : g_word
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
        logic [DATA_W-1:0] word_reg;

        // Capture write-back data when this register is the destination.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            word_reg <= '0;
          end else if (wr_en && (rd_addr == IDX)) begin
            word_reg <= wr_data;
          end
        end

        assign rf_words[gi] = word_reg;
      end
    end
  endgenerate

  // Combinational read of one port: out-of-range reads give zero, and a
  // same-cycle write to the addressed register is forwarded. Bypass is held
  // off during reset so the operands read zero while rst_n is low.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if ({1'b0, addr} < NUM_REGS_L) begin
      val = rf_words[addr];
    end
    if (rst_n && wr_en && (rd_addr == addr)) begin
      val = wr_data;
    end
    return val;
  endfunction

  // Operand read ports for ALU data1/data2.
  always_comb begin
    data1 = read_port(rs_addr);
    data2 = read_port(rt_addr);
  end

  // Status flags latch the ALU outputs only on a flag-capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zero_reg     <= 1'b0;
      flag_negative_reg <= 1'b0;
    end else if (cu_flagWrite) begin
      flag_zero_reg     <= alu_zero;
      flag_negative_reg <= alu_negative;
    end
  end

  assign flag_zero     = flag_zero_reg;
  assign flag_negative = flag_negative_reg;

endmodule

// File: doc/reg_file_flags.md
Name: reg_file_flags

Overview:
- Register bank directly upstream of the ALU. It supplies the two ALU operands (data1, data2) and captures the ALU result on write-back.
- Also holds the architectural status flags (zero, negative) latched from the ALU flag outputs; the branch logic in the control unit consumes them.
- Single clock domain. Asynchronous active-low reset.

Parameters:
- NUM_REGS, 32, number of general-purpose registers (power of two, 2..32).
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width; must equal log2(NUM_REGS).

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- rs_addr  in  ADDR_W  read address, operand A
- rt_addr  in  ADDR_W  read address, operand B
- data1  out  DATA_W  operand A to ALU data1
- data2  out  DATA_W  operand B to ALU data2
- cu_regWrite  in  1  write enable from control unit
- rd_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write-back data (ALU aluOut)
- cu_flagWrite  in  1  flag-capture enable from control unit
- alu_zero  in  1  ALU zero output
- alu_negative  in  1  ALU negative output
- flag_zero  out  1  latched zero flag
- flag_negative  out  1  latched negative flag

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, flag_zero = 0, flag_negative = 0.
  - data1/data2 therefore read 0 during reset.
  - While rst_n is low, writes and flag captures are ignored regardless of enables.
- Deassertion: first rising edge with rst_n high performs normal operation.
- Register 0 is hardwired to zero.
  - Writes with rd_addr == 0 are discarded.
  - Reads of address 0 always return 0, including through the bypass path.
- Write: on rising clk, if cu_regWrite = 1 and rd_addr != 0, reg[rd_addr] <= wr_data. One-cycle write latency.
- Read: combinational, zero latency. data1 = reg[rs_addr], data2 = reg[rt_addr].
- Write-through bypass: if cu_regWrite = 1, rd_addr != 0 and rd_addr == rs_addr, then data1 = wr_data in the same cycle (pre-edge). Same rule applies to data2 with rt_addr.
  - Both ports may bypass simultaneously.
- rs_addr == rt_addr: both outputs return identical values.
- Flags: on rising clk, if cu_flagWrite = 1, flag_zero <= alu_zero and flag_negative <= alu_negative. Otherwise both hold.
  - No flag bypass; new values are visible the cycle after capture.
- Independence: cu_regWrite and cu_flagWrite act independently, and both may be active in the same cycle.
- Addresses >= NUM_REGS (only when NUM_REGS < 2^ADDR_W):
  - Reads return 0.
  - Writes are discarded.
- X-safety: when cu_regWrite = 0, rd_addr and wr_data are don't-care; no register may change.

Test Plan:
1. Reset: write 0xDEADBEEF to r5, assert rst_n low mid-cycle -> data1 (rs=5) reads 0 immediately (asynchronous); after release r5 still reads 0.
2. Write/read: write 0x00000011 to r3, then 0xFFFFFFF0 to r4; set rs=3, rt=4 -> data1 = 0x00000011, data2 = 0xFFFFFFF0 the cycle after the second write.
3. r0: cu_regWrite=1, rd=0, wr_data=0x12345678 -> after the edge, rs=0 gives data1 = 0; during the write cycle, rs=0 also gives 0 (no bypass).
4. Bypass: r7 holds 0x1; in the same cycle drive cu_regWrite=1, rd=7, wr_data=0xA5A5A5A5, rs=7, rt=7 -> data1 = data2 = 0xA5A5A5A5 before the edge and after it.
5. Flags:
   - cu_flagWrite=1 with zero=1, negative=0 -> next cycle flag_zero=1, flag_negative=0.
   - Then cu_flagWrite=0 with zero=0, negative=1 -> flags unchanged.
   - Then cu_flagWrite=1 -> flag_zero=0, flag_negative=1.
6. Simultaneous: cu_regWrite=1 (rd=9, 0xFFFFFFFF) together with cu_flagWrite=1 (negative=1) in one cycle -> r9 = 0xFFFFFFFF and flag_negative = 1 after the same edge; random traffic compared against a reference model for 10k cycles.
